// File: rtl/parity_serial_tx_if.sv
// Producer-side handshake bundle for parity_serial_tx.
//   in_valid : producer has a word on in_data
//   in_ready : transmitter can accept a word (high only in IDLE)
//   in_data  : DATA_W-bit word to transmit
//   odd_mode : 0 = even parity, 1 = odd parity; sampled at accept
interface parity_serial_tx_if #(
   parameter int unsigned DATA_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              odd_mode;

   modport master (output in_valid, output in_data, output odd_mode, input in_ready);
   modport slave  (input in_valid, input in_data, input odd_mode, output in_ready);
endinterface

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, parity bit,
// stop bit; every bit is held for CLKS_PER_BIT clocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the valid/ready word handshake (parity_serial_tx_if)
//   tx         : serial line, idles high
//   busy       : high from START through STOP
//   done       : one-cycle pulse in the first IDLE cycle after a frame
//   frame_cnt  : completed frames, wraps at 256
module parity_serial_tx #(
   parameter int unsigned DATA_W       = 4,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   parity_serial_tx_if.slave     bus,
   output logic                  tx,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            frame_cnt
);

   localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   bit_q, bit_d;
   logic [DATA_W-1:0]  shreg_q, shreg_d;
   logic               par_q, par_d;
   logic               tx_d, busy_d, done_d;
   logic [7:0]         frame_cnt_d;
   logic               bit_end;

   assign bus.in_ready = (state_q == IDLE);
   assign bit_end      = (div_q == DIV_LAST);

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         tx        <= tx_d;
         busy      <= busy_d;
         done      <= done_d;
         frame_cnt <= frame_cnt_d;
      end
   end

   // Next state; tx is computed one edge ahead so the line changes on the
   // same edge as the state it belongs to
   always_comb begin
      state_d     = state_q;
      div_d       = bit_end ? '0 : div_q + DIV_W'(1);
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      par_d       = par_q;
      tx_d        = tx;
      busy_d      = busy;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt;

      unique case (state_q)
         IDLE: begin
            div_d = '0;
            tx_d  = 1'b1;
            if (bus.in_valid) begin
               shreg_d = bus.in_data;
               par_d   = (^bus.in_data) ^ bus.odd_mode;
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shreg_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = PARITY;
                  tx_d    = par_q;
               end else begin
                  bit_d = bit_q + CNT_W'(1);
                  tx_d  = shreg_d[0];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d     = IDLE;
               tx_d        = 1'b1;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               frame_cnt_d = frame_cnt + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed self-checking bench for parity_serial_tx (CLKS_PER_BIT=4 and =1 instances).
module tb_parity_serial_tx;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   parity_serial_tx_if #(.DATA_W(4)) bus0 ();
   parity_serial_tx_if #(.DATA_W(4)) bus1 ();

   logic       tx0, busy0, done0;
   logic [7:0] cnt0;
   logic       tx1, busy1, done1;
   logic [7:0] cnt1;

   parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus0),
      .tx(tx0), .busy(busy0), .done(done0), .frame_cnt(cnt0)
   );

   parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1),
      .tx(tx1), .busy(busy1), .done(done1), .frame_cnt(cnt1)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected per-cycle line pattern of one frame, bit 0 = first cycle after accept
   function automatic logic [63:0] frame_bits(input logic [3:0] d, input logic p, input int cpb);
      logic [6:0]  b;
      logic [63:0] v;
      b = {1'b1, p, d, 1'b0};
      v = '0;
      for (int i = 0; i < 7; i++)
         for (int c = 0; c < cpb; c++)
            v[i*cpb+c] = b[i];
      return v;
   endfunction

   // One frame on the CLKS_PER_BIT=4 instance; called at a negedge with in_ready high.
   // Inputs are scrambled mid-frame to show they are not re-sampled.
   task automatic run_frame(input string tag, input logic [3:0] d, input logic odd, input logic p);
      logic [63:0] obs;
      int          early;
      obs   = '0;
      early = 0;
      bus0.in_valid = 1'b1;
      bus0.in_data  = d;
      bus0.odd_mode = odd;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      for (int k = 0; k < 28; k++) begin
         obs[k] = tx0;
         if (done0) early++;
         if (k == 6) begin
            bus0.in_data  = ~d;
            bus0.odd_mode = ~odd;
         end
         if (k == 15) bus0.in_data = d ^ 4'h6;
         @(negedge clk);
      end
      check({tag, "_tx"},    obs, frame_bits(d, p, 4));
      check({tag, "_early"}, 64'(early), 64'd0);
      check({tag, "_done"},  64'(done0), 64'd1);
      check({tag, "_busy"},  64'(busy0), 64'd0);
      check({tag, "_ready"}, 64'(bus0.in_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] obs_tx, obs_rdy, exp_tx;
      int          bad, dones, runs, run_len, bad_len;
      logic [63:0] obs1;

      rst_n = 1'b0;
      bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.odd_mode = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.odd_mode = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_tx",    64'(tx0), 64'd1);
      check("rst_busy",  64'(busy0), 64'd0);
      check("rst_done",  64'(done0), 64'd0);
      check("rst_ready", 64'(bus0.in_ready), 64'd1);
      check("rst_cnt",   64'(cnt0), 64'd0);
      check("rst_cnt1",  64'(cnt1), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: even parity, 1011 -> parity 1
      run_frame("even_1011", 4'b1011, 1'b0, 1'b1);
      check("even_1011_cnt", 64'(cnt0), 64'd1);

      // 2: odd parity cases
      run_frame("odd_0000", 4'b0000, 1'b1, 1'b1);
      run_frame("odd_0111", 4'b0111, 1'b1, 1'b0);
      check("odd_cnt", 64'(cnt0), 64'd3);

      // 3: back-to-back, in_valid held high, A (even) then 5 (odd)
      obs_tx  = '0;
      obs_rdy = '0;
      bus0.in_valid = 1'b1;
      bus0.in_data  = 4'hA;
      bus0.odd_mode = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 57; k++) begin
         obs_tx[k]  = tx0;
         obs_rdy[k] = bus0.in_ready;
         if (k == 3)  begin bus0.in_data = 4'hF; bus0.odd_mode = 1'b1; end
         if (k == 10) begin bus0.in_data = 4'h0; bus0.odd_mode = 1'b0; end
         if (k == 20) begin bus0.in_data = 4'h5; bus0.odd_mode = 1'b1; end
         if (k == 29) begin bus0.in_valid = 1'b0; bus0.in_data = 4'hC; bus0.odd_mode = 1'b0; end
         @(negedge clk);
      end
      exp_tx = frame_bits(4'hA, 1'b0, 4) | (64'd1 << 28) | (frame_bits(4'h5, 1'b1, 4) << 29);
      check("b2b_tx",    obs_tx, exp_tx);
      check("b2b_ready", obs_rdy, 64'd1 << 28);
      check("b2b_done",  64'(done0), 64'd1);
      check("b2b_cnt",   64'(cnt0), 64'd5);

      // 4: reset during DATA bit 2 of a 4'h3 frame
      bus0.in_valid = 1'b1;
      bus0.in_data  = 4'h3;
      bus0.odd_mode = 1'b0;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      repeat (13) @(negedge clk);
      check("mid_pre_tx",   64'(tx0), 64'd0);
      check("mid_pre_busy", 64'(busy0), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx",   64'(tx0), 64'd1);
      check("mid_rst_busy", 64'(busy0), 64'd0);
      check("mid_rst_cnt",  64'(cnt0), 64'd0);
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (done0 || busy0 || !tx0) bad++;
      end
      check("mid_rst_hold", 64'(bad), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rel_done", 64'(done0), 64'd0);
      run_frame("rst_recover", 4'h3, 1'b0, 1'b0);
      check("rst_recover_cnt", 64'(cnt0), 64'd1);

      // 6: idle stability
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) bad++;
      end
      check("idle_stable", 64'(bad), 64'd0);

      // 5: CLKS_PER_BIT=1, 256 back-to-back frames of 4'h9 (parity 0)
      bus1.in_data  = 4'h9;
      bus1.odd_mode = 1'b0;
      bus1.in_valid = 1'b1;
      obs1    = '0;
      dones   = 0;
      runs    = 0;
      run_len = 0;
      bad_len = 0;
      for (int k = 1; k <= 2048; k++) begin
         @(negedge clk);
         if (k <= 7) obs1[k-1] = tx1;
         if (busy1) run_len++;
         else if (run_len != 0) begin
            if (run_len != 7) bad_len++;
            runs++;
            run_len = 0;
         end
         if (done1) dones++;
         if (k == 2040) check("wrap_cnt255", 64'(cnt1), 64'd255);
         if (k == 2048) bus1.in_valid = 1'b0;
      end
      check("wrap_tx",    obs1, frame_bits(4'h9, 1'b0, 1));
      check("wrap_dones", 64'(dones), 64'd256);
      check("wrap_runs",  64'(runs), 64'd256);
      check("wrap_len",   64'(bad_len), 64'd0);
      check("wrap_done",  64'(done1), 64'd1);
      check("wrap_cnt0",  64'(cnt1), 64'd0);
      @(negedge clk);
      check("wrap_after_busy", 64'(busy1), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
